// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus slave: state encoding, bus levels and sizing helper.
package bus_pkg;

  localparam int SID_WIDTH_DEF = 3;

  localparam logic BUS_START   = 1'b0;
  localparam logic BUS_ACK     = 1'b0;
  localparam logic BUS_ACK_END = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_START2        = 4'd1,
    ST_SID           = 4'd2,
    ST_WAIT_PEER     = 4'd3,
    ST_ADDR          = 4'd4,
    ST_BURST         = 4'd5,
    ST_ADDR_ACK      = 4'd6,
    ST_WR_WAIT_START = 4'd7,
    ST_WR_DATA       = 4'd8,
    ST_WR_MEM        = 4'd9,
    ST_WR_GRANT      = 4'd10,
    ST_WR_ACK        = 4'd11,
    ST_RD_MEM        = 4'd12,
    ST_RD_GRANT      = 4'd13,
    ST_RD_TX         = 4'd14
  } state_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Serial shift register with a bit counter; the active field length is selected at run time.
// Receive reads par_shift (low bits), transmit loads left-aligned data and reads serial_out.
module bus_shift_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_shift,
  output logic             serial_out,
  output logic             last
);

  logic [WIDTH-1:0] data_reg;
  logic [LEN_W-1:0] cnt_reg;

  generate
    if (WIDTH == 1) begin : g_one
      assign par_shift = serial_in;
    end else begin : g_multi
      assign par_shift = {data_reg[WIDTH-2:0], serial_in};
    end
  endgenerate

  assign serial_out = data_reg[WIDTH-1];
  // Counter wraps on the final bit so the next field starts from zero.
  assign last       = (cnt_reg == len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      data_reg <= par_in;
      cnt_reg  <= '0;
    end else if (shift_en) begin
      data_reg <= par_shift;
      cnt_reg  <= last ? '0 : cnt_reg + LEN_W'(1);
    end
  end

endmodule

// File: rtl/bus_slave_burst.sv
// Serial-bus memory slave: decodes ID/address/burst, then performs burst writes or reads
// against a local memory port, with bus acknowledge, arbiter grant and wait timeouts.
module bus_slave_burst
  import bus_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH = 15,
  parameter int                   DATA_WIDTH    = 8,
  parameter int                   SID_WIDTH     = SID_WIDTH_DEF,
  parameter logic [SID_WIDTH-1:0] SELF_ID       = '0,
  parameter int                   BURST_WIDTH   = 2,
  parameter int                   TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_wrt,
  input  logic                     bus_util,
  input  logic                     module_dv,
  input  logic                     arbiter_cmd_in,
  input  logic [DATA_WIDTH-1:0]    data_in_parellel,
  inout  wire                      data_bus_serial,
  output logic                     write_en_internal,
  output logic                     req_int_data,
  output logic                     busy_out,
  output logic                     timeout_err,
  output logic [DATA_WIDTH-1:0]    data_out_parellel,
  output logic [ADDRESS_WIDTH-1:0] addr_buff,
  output logic [BURST_WIDTH-1:0]   burst_idx,
  output logic [3:0]               state_wire
);

  localparam int SR_W  = max_of4(ADDRESS_WIDTH, DATA_WIDTH, SID_WIDTH, BURST_WIDTH);
  localparam int LEN_W = $clog2(SR_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t state_reg, state_next;
  logic                     phase_reg;
  logic [TO_W-1:0]          tcnt_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [BURST_WIDTH-1:0]   blen_reg, bidx_reg;
  logic [DATA_WIDTH-1:0]    dout_reg;
  logic                     we_reg, req_reg, busy_reg, tout_reg;

  logic             sr_load, sr_shift, sr_serial, sr_last;
  logic [LEN_W-1:0] sr_len;
  logic [SR_W-1:0]  sr_par_shift, sr_par_in;

  logic bus_oe, bus_out;
  logic ld_addr, ld_burst, wr_word, next_word, rd_entry, dv_take, tout;
  logic wait_st, tout_hit, more_words;

  bus_shift_reg #(.WIDTH(SR_W), .LEN_W(LEN_W)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .shift_en  (sr_shift),
    .serial_in (data_bus_serial),
    .len       (sr_len),
    .par_in    (sr_par_in),
    .par_shift (sr_par_shift),
    .serial_out(sr_serial),
    .last      (sr_last)
  );

  assign sr_par_in  = SR_W'(data_in_parellel) << (SR_W - DATA_WIDTH);
  assign wait_st    = state_reg inside {ST_WR_WAIT_START, ST_WR_GRANT, ST_RD_GRANT};
  assign tout_hit   = (tcnt_reg == TO_W'(TIMEOUT - 1));
  assign more_words = (bidx_reg < blen_reg);

  always_comb begin
    sr_len = LEN_W'(SID_WIDTH);
    case (state_reg)
      ST_ADDR:             sr_len = LEN_W'(ADDRESS_WIDTH);
      ST_BURST:            sr_len = LEN_W'(BURST_WIDTH);
      ST_WR_DATA, ST_RD_TX: sr_len = LEN_W'(DATA_WIDTH);
      default:             sr_len = LEN_W'(SID_WIDTH);
    endcase
  end

  // Bus drive depends only on registered state so it never loops through the bus input.
  assign bus_oe = state_reg inside {ST_ADDR_ACK, ST_WR_ACK, ST_RD_TX};
  always_comb begin
    bus_out = BUS_ACK;
    if (state_reg == ST_WR_ACK && phase_reg)     bus_out = BUS_ACK_END;
    else if (state_reg == ST_RD_TX && phase_reg) bus_out = sr_serial;
  end
  assign data_bus_serial = bus_oe ? bus_out : 1'bz;

  always_comb begin
    state_next = state_reg;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    ld_addr    = 1'b0;
    ld_burst   = 1'b0;
    wr_word    = 1'b0;
    next_word  = 1'b0;
    rd_entry   = 1'b0;
    dv_take    = 1'b0;
    tout       = 1'b0;
    case (state_reg)
      ST_IDLE:      if (data_bus_serial == BUS_START) state_next = ST_START2;
      ST_START2:    state_next = (data_bus_serial == BUS_START) ? ST_SID : ST_WAIT_PEER;
      ST_SID: begin
        sr_shift = 1'b1;
        if (sr_last)
          state_next = (sr_par_shift[SID_WIDTH-1:0] == SELF_ID) ? ST_ADDR : ST_WAIT_PEER;
      end
      ST_WAIT_PEER: if (bus_util) state_next = ST_IDLE;
      ST_ADDR: begin
        sr_shift = 1'b1;
        if (sr_last) begin
          ld_addr    = 1'b1;
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        sr_shift = 1'b1;
        if (sr_last) begin
          ld_burst   = 1'b1;
          state_next = ST_ADDR_ACK;
        end
      end
      ST_ADDR_ACK: if (phase_reg) begin
        state_next = rd_wrt ? ST_WR_WAIT_START : ST_RD_MEM;
        rd_entry   = !rd_wrt;
      end
      ST_WR_WAIT_START: begin
        if (data_bus_serial == BUS_START) state_next = ST_WR_DATA;
        else if (tout_hit) begin
          tout       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        sr_shift = 1'b1;
        if (sr_last) begin
          wr_word    = 1'b1;
          state_next = ST_WR_MEM;
        end
      end
      // A done strobe coinciding with the write pulse belongs to an earlier request.
      ST_WR_MEM: if (module_dv && !we_reg) begin
        dv_take    = 1'b1;
        next_word  = more_words;
        state_next = more_words ? ST_WR_WAIT_START : ST_WR_GRANT;
      end
      ST_WR_GRANT: begin
        if (arbiter_cmd_in) state_next = ST_WR_ACK;
        else if (tout_hit) begin
          tout       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WR_ACK:   if (phase_reg) state_next = ST_IDLE;
      ST_RD_MEM: if (module_dv) begin
        dv_take    = 1'b1;
        sr_load    = 1'b1;
        state_next = ST_RD_GRANT;
      end
      ST_RD_GRANT: begin
        if (arbiter_cmd_in) state_next = ST_RD_TX;
        else if (tout_hit) begin
          tout       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_RD_TX: if (phase_reg) begin
        sr_shift = 1'b1;
        if (sr_last) begin
          next_word  = more_words;
          rd_entry   = more_words;
          state_next = more_words ? ST_RD_MEM : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      phase_reg <= 1'b0;
      tcnt_reg  <= '0;
      addr_reg  <= '0;
      blen_reg  <= '0;
      bidx_reg  <= '0;
      dout_reg  <= '0;
      we_reg    <= 1'b0;
      req_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      tout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= (state_next == state_reg);
      tcnt_reg  <= (wait_st && state_next == state_reg) ? tcnt_reg + TO_W'(1) : '0;
      we_reg    <= wr_word;
      req_reg   <= rd_entry;
      tout_reg  <= tout;
      if (ld_addr)  addr_reg <= sr_par_shift[ADDRESS_WIDTH-1:0];
      if (ld_burst) begin
        blen_reg <= sr_par_shift[BURST_WIDTH-1:0];
        bidx_reg <= '0;
      end
      if (next_word) begin
        addr_reg <= addr_reg + ADDRESS_WIDTH'(1);
        bidx_reg <= bidx_reg + BURST_WIDTH'(1);
      end
      if (wr_word) dout_reg <= sr_par_shift[DATA_WIDTH-1:0];
      if (wr_word || rd_entry) busy_reg <= 1'b1;
      else if (dv_take)        busy_reg <= 1'b0;
    end
  end

  assign write_en_internal = we_reg;
  assign req_int_data      = req_reg;
  assign busy_out          = busy_reg;
  assign timeout_err       = tout_reg;
  assign data_out_parellel = dout_reg;
  assign addr_buff         = addr_reg;
  assign burst_idx         = bidx_reg;
  assign state_wire        = state_reg;

endmodule

// File: tb/tb_bus_slave_burst.sv
// Directed bench for bus_slave_burst: write burst, read single, address wrap, ID mismatch,
// timeout and reset during read transmission.
module tb_bus_slave_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_wrt = 1'b0;
  logic        bus_util = 1'b0;
  logic        module_dv = 1'b0;
  logic        arbiter_cmd_in = 1'b0;
  logic [7:0]  data_in_parellel = 8'h00;
  logic        tb_val = 1'b1;
  wire         data_bus_serial;
  logic        write_en_internal, req_int_data, busy_out, timeout_err;
  logic [7:0]  data_out_parellel;
  logic [14:0] addr_buff;
  logic [1:0]  burst_idx;
  logic [3:0]  state_wire;
  int          checks = 0;
  int          errors = 0;
  logic        driven;

  // The master side keeps the line at its idle level whenever the slave is not driving.
  assign data_bus_serial = dut.bus_oe ? 1'bz : tb_val;

  always #5 clk = ~clk;

  bus_slave_burst dut (
    .clk              (clk),
    .rst              (rst),
    .rd_wrt           (rd_wrt),
    .bus_util         (bus_util),
    .module_dv        (module_dv),
    .arbiter_cmd_in   (arbiter_cmd_in),
    .data_in_parellel (data_in_parellel),
    .data_bus_serial  (data_bus_serial),
    .write_en_internal(write_en_internal),
    .req_int_data     (req_int_data),
    .busy_out         (busy_out),
    .timeout_err      (timeout_err),
    .data_out_parellel(data_out_parellel),
    .addr_buff        (addr_buff),
    .burst_idx        (burst_idx),
    .state_wire       (state_wire)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic [31:0] vv;
    vv = v;
    for (int i = n - 1; i >= 0; i--) begin
      tb_val = vv[i];
      step();
    end
    tb_val = 1'b1;
  endtask

  task automatic header(input logic [2:0] sid, input logic [14:0] addr, input logic [1:0] bf);
    send_bits(32'd0, 2);
    send_bits({29'd0, sid}, 3);
    send_bits({17'd0, addr}, 15);
    send_bits({30'd0, bf}, 2);
  endtask

  task automatic addr_ack(input logic wr);
    chk("ack0_oe", {31'd0, dut.bus_oe}, 32'd1);
    chk("ack0_val", {31'd0, dut.bus_out}, 32'd0);
    rd_wrt = ~wr;
    step();
    chk("ack1_oe", {31'd0, dut.bus_oe}, 32'd1);
    chk("ack1_val", {31'd0, dut.bus_out}, 32'd0);
    rd_wrt = wr;
    step();
    rd_wrt = 1'b0;
    chk("ack_release", {31'd0, dut.bus_oe}, 32'd0);
    chk("ack_dir", {28'd0, state_wire}, wr ? 32'd7 : 32'd12);
  endtask

  task automatic write_word(input logic [7:0] d, input logic [14:0] exp_addr, input logic dv_early);
    chk("ww_wait", {28'd0, state_wire}, 32'd7);
    send_bits(32'd0, 1);
    chk("ww_data_state", {28'd0, state_wire}, 32'd8);
    send_bits({24'd0, d}, 8);
    chk("ww_we", {31'd0, write_en_internal}, 32'd1);
    chk("ww_dout", {24'd0, data_out_parellel}, {24'd0, d});
    chk("ww_addr", {17'd0, addr_buff}, {17'd0, exp_addr});
    chk("ww_busy", {31'd0, busy_out}, 32'd1);
    module_dv = dv_early;
    step();
    chk("ww_we_pulse", {31'd0, write_en_internal}, 32'd0);
    chk("ww_mem_hold", {28'd0, state_wire}, 32'd9);
    module_dv = 1'b1;
    step();
    module_dv = 1'b0;
    chk("ww_busy_clr", {31'd0, busy_out}, 32'd0);
  endtask

  task automatic read_word(input logic [7:0] d, input logic [14:0] exp_addr, input logic [1:0] exp_idx);
    logic [7:0] dd;
    dd = d;
    chk("rd_state", {28'd0, state_wire}, 32'd12);
    chk("rd_req", {31'd0, req_int_data}, 32'd1);
    chk("rd_busy", {31'd0, busy_out}, 32'd1);
    chk("rd_addr", {17'd0, addr_buff}, {17'd0, exp_addr});
    chk("rd_idx", {30'd0, burst_idx}, {30'd0, exp_idx});
    step();
    chk("rd_req_pulse", {31'd0, req_int_data}, 32'd0);
    module_dv = 1'b1;
    data_in_parellel = d;
    step();
    module_dv = 1'b0;
    data_in_parellel = 8'h00;
    chk("rd_grant", {28'd0, state_wire}, 32'd13);
    chk("rd_busy_clr", {31'd0, busy_out}, 32'd0);
    step();
    arbiter_cmd_in = 1'b1;
    step();
    arbiter_cmd_in = 1'b0;
    chk("tx_start_oe", {31'd0, dut.bus_oe}, 32'd1);
    chk("tx_start_val", {31'd0, dut.bus_out}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      step();
      chk("tx_bit_oe", {31'd0, dut.bus_oe}, 32'd1);
      chk($sformatf("tx_bit%0d", i), {31'd0, dut.bus_out}, {31'd0, dd[i]});
    end
    step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, {28'd0, state_wire}, 32'd0);
    chk({tag, "_oe"}, {31'd0, dut.bus_oe}, 32'd0);
    chk({tag, "_we"}, {31'd0, write_en_internal}, 32'd0);
    chk({tag, "_req"}, {31'd0, req_int_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    chk({tag, "_tout"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_dout"}, {24'd0, data_out_parellel}, 32'd0);
    chk({tag, "_addr"}, {17'd0, addr_buff}, 32'd0);
    chk({tag, "_idx"}, {30'd0, burst_idx}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk_reset_state("reset");
    rst = 1'b0;
    step();

    // Write burst of three words at 0x0010
    header(3'd0, 15'h0010, 2'd2);
    addr_ack(1'b1);
    write_word(8'hA5, 15'h0010, 1'b1);
    chk("wb_addr1", {17'd0, addr_buff}, 32'h11);
    chk("wb_idx1", {30'd0, burst_idx}, 32'd1);
    write_word(8'h3C, 15'h0011, 1'b0);
    chk("wb_idx2", {30'd0, burst_idx}, 32'd2);
    write_word(8'hFF, 15'h0012, 1'b0);
    chk("wb_grant", {28'd0, state_wire}, 32'd10);
    step();
    step();
    chk("wb_grant_wait", {28'd0, state_wire}, 32'd10);
    arbiter_cmd_in = 1'b1;
    step();
    arbiter_cmd_in = 1'b0;
    chk("wack0_oe", {31'd0, dut.bus_oe}, 32'd1);
    chk("wack0_val", {31'd0, dut.bus_out}, 32'd0);
    step();
    chk("wack1_oe", {31'd0, dut.bus_oe}, 32'd1);
    chk("wack1_val", {31'd0, dut.bus_out}, 32'd1);
    step();
    chk("wack_idle", {28'd0, state_wire}, 32'd0);
    chk("wack_release", {31'd0, dut.bus_oe}, 32'd0);
    step();

    // Read single word at 0x7FFF
    header(3'd0, 15'h7FFF, 2'd0);
    addr_ack(1'b0);
    read_word(8'h5A, 15'h7FFF, 2'd0);
    chk("rs_idle", {28'd0, state_wire}, 32'd0);
    chk("rs_release", {31'd0, dut.bus_oe}, 32'd0);

    // Two-word read wrapping from 0x7FFF to 0x0000
    header(3'd0, 15'h7FFF, 2'd1);
    addr_ack(1'b0);
    read_word(8'hC3, 15'h7FFF, 2'd0);
    read_word(8'h81, 15'h0000, 2'd1);
    chk("wrap_idle", {28'd0, state_wire}, 32'd0);

    // Foreign slave ID: stay off the bus until the peer transfer ends
    driven = 1'b0;
    send_bits(32'd0, 2);
    send_bits(32'd3, 3);
    chk("mis_wait_peer", {28'd0, state_wire}, 32'd3);
    for (int i = 0; i < 24; i++) begin
      tb_val = i[0];
      step();
      driven = driven | dut.bus_oe;
    end
    tb_val = 1'b1;
    chk("mis_never_driven", {31'd0, driven}, 32'd0);
    chk("mis_still_wait", {28'd0, state_wire}, 32'd3);
    bus_util = 1'b1;
    step();
    bus_util = 1'b0;
    chk("mis_idle", {28'd0, state_wire}, 32'd0);

    // Missing start bit for the second burst word
    header(3'd0, 15'h0020, 2'd1);
    addr_ack(1'b1);
    write_word(8'h11, 15'h0020, 1'b0);
    chk("to_wait", {28'd0, state_wire}, 32'd7);
    repeat (15) step();
    chk("to_not_yet", {28'd0, state_wire}, 32'd7);
    chk("to_err_low", {31'd0, timeout_err}, 32'd0);
    step();
    chk("to_idle", {28'd0, state_wire}, 32'd0);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_release", {31'd0, dut.bus_oe}, 32'd0);
    step();
    chk("to_err_pulse", {31'd0, timeout_err}, 32'd0);

    // Reset while transmitting read data
    header(3'd0, 15'h0100, 2'd0);
    addr_ack(1'b0);
    step();
    module_dv = 1'b1;
    data_in_parellel = 8'hFF;
    step();
    module_dv = 1'b0;
    arbiter_cmd_in = 1'b1;
    step();
    arbiter_cmd_in = 1'b0;
    chk("rtx_state", {28'd0, state_wire}, 32'd14);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("midrst");
    step();
    chk("midrst_hold_idle", {28'd0, state_wire}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_slave_burst.md
BUS_SLAVE_BURST -- requirements
Module: bus_slave_burst

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 15: memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8: data word width in bits.
REQ-003 Parameter SID_WIDTH, default 3: slave ID field width in bits.
REQ-004 Parameter SELF_ID, default 0: this slave's ID, SID_WIDTH bits.
REQ-005 Parameter BURST_WIDTH, default 2: burst field width; burst length = field + 1 words (1..2^BURST_WIDTH).
REQ-006 Parameter TIMEOUT, default 16: idle-cycle limit while awaiting master or arbiter.
REQ-007 Ports: clk in 1, single clock; rst in 1, synchronous, active-high (already decided).
REQ-008 Ports: rd_wrt in 1 (1=write, 0=read, sampled at address ack); bus_util in 1; module_dv in 1 (memory done); arbiter_cmd_in in 1 (bus grant).
REQ-009 Ports: data_in_parellel in DATA_WIDTH; data_bus_serial inout 1, sampled every posedge, MSB first.
REQ-010 Ports: write_en_internal, req_int_data, busy_out, timeout_err out 1; data_out_parellel out DATA_WIDTH; addr_buff out ADDRESS_WIDTH; burst_idx out BURST_WIDTH; state_wire out 4.

Function
REQ-011 States: IDLE, START2, SID, WAIT_PEER, ADDR, BURST, ADDR_ACK, WR_WAIT_START, WR_DATA, WR_MEM, WR_GRANT, WR_ACK, RD_MEM, RD_GRANT, RD_TX; state_wire = encoding.
REQ-012 IDLE -> START2 on data_bus_serial=0; START2 -> SID on 0, else WAIT_PEER.
REQ-013 SID: shift SID_WIDTH bits; match SELF_ID -> ADDR, mismatch -> WAIT_PEER; WAIT_PEER -> IDLE when bus_util=1.
REQ-014 ADDR shifts ADDRESS_WIDTH bits into addr_buff; BURST shifts BURST_WIDTH bits into burst length register; burst_idx cleared to 0.
REQ-015 ADDR_ACK: slave drives 0 for exactly 2 cycles, then releases to Z; rd_wrt sampled in second cycle selects WR_WAIT_START or RD_MEM.
REQ-016 Bus driven only in ADDR_ACK, WR_ACK, RD_TX; Z in all other states and during reset.
REQ-017 WR_WAIT_START: a 0 sample is the start bit -> WR_DATA, which shifts DATA_WIDTH bits.
REQ-018 On last data bit: data_out_parellel loaded, write_en_internal high exactly 1 cycle, busy_out=1, -> WR_MEM.
REQ-019 WR_MEM: on module_dv, busy_out=0; if burst_idx < length-1: addr_buff+1, burst_idx+1, -> WR_WAIT_START; else -> WR_GRANT.
REQ-020 WR_GRANT -> WR_ACK on arbiter_cmd_in; WR_ACK drives 0 one cycle, 1 one cycle, then IDLE.
REQ-021 RD_MEM: req_int_data high exactly 1 cycle on entry, busy_out=1; on module_dv latch data_in_parellel, busy_out=0, -> RD_GRANT.
REQ-022 RD_GRANT -> RD_TX on arbiter_cmd_in; RD_TX drives start bit 0 then DATA_WIDTH bits MSB first (DATA_WIDTH+1 cycles).
REQ-023 After RD_TX: more words -> addr_buff+1, burst_idx+1, RD_MEM; else IDLE.
REQ-024 addr_buff increment wraps modulo 2^ADDRESS_WIDTH.
REQ-025 Timeout counter runs in WR_WAIT_START, WR_GRANT, RD_GRANT; clears on leaving state; at TIMEOUT cycles -> IDLE, timeout_err high 1 cycle, outputs released.
REQ-026 module_dv and arbiter_cmd_in ignored outside their wait states; module_dv in same cycle as write_en_internal is not taken until WR_MEM.

Reset
REQ-027 rst=1 at a posedge: state IDLE, all 1-bit outputs 0, data_out_parellel, addr_buff, burst_idx, counters 0, bus Z; holds mid-transaction, no partial write pulse.

Structure
REQ-028 Shared package bus_pkg: state encoding constants, SID_WIDTH default, bus ack/start level constants.
REQ-029 One sub-module bus_shift_reg: parametric serial-in/serial-out shift register with bit counter and done flag, used for SID, address, burst, data rx and tx.

Verification
REQ-030 Write burst: ID 0, addr 0x0010, burst field 2, data 0xA5,0x3C,0xFF -> three write_en_internal pulses at addr 0x0010/11/12, ack 0 then 1 after grant.
REQ-031 Read single: addr 0x7FFF, memory returns 0x5A -> req_int_data pulse, after grant bus shows 0,0,1,0,1,1,0,1,0.
REQ-032 Wrap: read burst 2 at addr 0x7FFF -> second word addressed 0x0000.
REQ-033 ID mismatch: ID 3 -> bus never driven, WAIT_PEER until bus_util=1, then IDLE.
REQ-034 Timeout: write burst, no second start bit for 16 cycles -> timeout_err pulse, IDLE, bus Z.
REQ-035 rst asserted mid RD_TX -> next cycle bus Z, all outputs 0, state_wire IDLE.
